// File: rtl/rv_mem_arbiter_pkg.sv
// Shared types for the rv32_core local SRAM arbiter: read-owner tags and the
// width of the host starvation counter.
package rv_mem_arbiter_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{valid: 1'b0, owner: OWN_CORE};

  // Wide enough for the largest legal STARVE_MAX (15)
  localparam int CNT_W = 4;

endpackage

// File: rtl/rv_mem_arbiter_tag_pipe.sv
// In-flight read owner pipe: a DEPTH-deep shift register of tags, so the tag
// of a read leaves the pipe in the same cycle its SRAM data is valid.
module rv_mem_arbiter_tag_pipe
  import rv_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic cclk,
  input  logic clr,
  input  tag_t push,
  output tag_t tail
);

  tag_t stage [DEPTH];

  always_ff @(posedge cclk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_EMPTY;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[DEPTH-1];

endmodule

// File: rtl/rv_mem_arbiter.sv
// Two-requester arbiter for the rv32_core local SRAM: the core data bus has
// fixed priority, the host port gets a guaranteed slot via a starvation counter.
module rv_mem_arbiter
  import rv_mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          cclk,
  input  logic          reset,
  input  logic [AW-1:0] adr,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [31:0]   dw,
  output logic [31:0]   dr,
  output logic          rdy,
  input  logic [AW-1:0] p_adr,
  input  logic          p_we,
  input  logic          p_re,
  input  logic [31:0]   p_dw,
  output logic [31:0]   p_dr,
  output logic          p_ack,
  output logic [AW-1:0] m_adr,
  output logic [3:0]    m_we,
  output logic          m_re,
  output logic [31:0]   m_dw,
  input  logic [31:0]   m_dr
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic             creq;
  logic             host_gnt;
  logic             core_gnt;
  logic             host_pend;
  logic             host_busy;
  logic             host_idle;
  logic             host_wr;
  logic [AW-1:0]    host_adr;
  logic [31:0]      host_dw;
  logic [CNT_W-1:0] starve_cnt;
  logic [31:0]      dr_q;
  logic             core_exit;
  logic             host_exit;
  tag_t             push_tag;
  tag_t             exit_tag;

  // Grants are suppressed during reset so nothing reaches the SRAM
  assign creq     = re | (|we);
  assign host_gnt = !reset && host_pend && (!creq || starve_cnt == STARVE_LIM);
  assign core_gnt = !reset && creq && !host_gnt;
  assign rdy      = !(creq && host_gnt);

  // The p_ack cycle still counts as busy so a level held through the ack is not re-latched
  assign host_idle = !host_pend && !host_busy && !p_ack;

  assign m_adr = host_gnt ? host_adr : adr;
  assign m_dw  = host_gnt ? host_dw  : dw;
  assign m_we  = host_gnt ? {4{host_wr}} : (core_gnt ? we : 4'h0);
  assign m_re  = host_gnt ? !host_wr : (core_gnt && re);

  always_comb begin
    push_tag       = TAG_EMPTY;
    push_tag.valid = m_re;
    push_tag.owner = host_gnt ? OWN_HOST : OWN_CORE;
  end

  rv_mem_arbiter_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .cclk (cclk),
    .clr  (reset),
    .push (push_tag),
    .tail (exit_tag)
  );

  assign core_exit = !reset && exit_tag.valid && (exit_tag.owner == OWN_CORE);
  assign host_exit = !reset && exit_tag.valid && (exit_tag.owner == OWN_HOST);
  assign dr        = core_exit ? m_dr : dr_q;

  always_ff @(posedge cclk) begin
    if (reset) begin
      dr_q <= '0;
    end else if (core_exit) begin
      dr_q <= m_dr;
    end
  end

  always_ff @(posedge cclk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (host_gnt || !host_pend) begin
      starve_cnt <= '0;
    end else if (core_gnt && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Host request latch and completion; a simultaneous write and read is taken as a write
  always_ff @(posedge cclk) begin
    if (reset) begin
      host_pend <= 1'b0;
      host_busy <= 1'b0;
      host_wr   <= 1'b0;
      host_adr  <= '0;
      host_dw   <= '0;
      p_ack     <= 1'b0;
      p_dr      <= '0;
    end else begin
      p_ack <= 1'b0;
      if (host_idle && (p_we || p_re)) begin
        host_pend <= 1'b1;
        host_wr   <= p_we;
        host_adr  <= p_adr;
        host_dw   <= p_dw;
      end
      if (host_gnt) begin
        host_pend <= 1'b0;
        if (host_wr) p_ack <= 1'b1;
        else         host_busy <= 1'b1;
      end
      if (host_exit) begin
        p_dr      <= m_dr;
        p_ack     <= 1'b1;
        host_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter with a behavioural SRAM model and a
// scoreboard of expected core and host read results.
module tb_rv_mem_arbiter;

  localparam int AW         = 32;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic          cclk = 1'b0;
  logic          reset;
  logic [AW-1:0] adr;
  logic [3:0]    we;
  logic          re;
  logic [31:0]   dw;
  logic [31:0]   dr;
  logic          rdy;
  logic [AW-1:0] p_adr;
  logic          p_we;
  logic          p_re;
  logic [31:0]   p_dw;
  logic [31:0]   p_dr;
  logic          p_ack;
  logic [AW-1:0] m_adr;
  logic [3:0]    m_we;
  logic          m_re;
  logic [31:0]   m_dw;
  logic [31:0]   m_dr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic preload = 1'b1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } core_exp_t;

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
  } host_exp_t;

  core_exp_t core_q[$];
  host_exp_t host_q[$];

  logic [31:0] mem     [1024];
  logic [31:0] rd_pipe [RD_LAT];

  always #5 cclk = ~cclk;

  always @(posedge cclk) cyc <= cyc + 1;

  rv_mem_arbiter #(
    .AW         (AW),
    .RD_LAT     (RD_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .cclk  (cclk),
    .reset (reset),
    .adr   (adr),
    .we    (we),
    .re    (re),
    .dw    (dw),
    .dr    (dr),
    .rdy   (rdy),
    .p_adr (p_adr),
    .p_we  (p_we),
    .p_re  (p_re),
    .p_dw  (p_dw),
    .p_dr  (p_dr),
    .p_ack (p_ack),
    .m_adr (m_adr),
    .m_we  (m_we),
    .m_re  (m_re),
    .m_dw  (m_dw),
    .m_dr  (m_dr)
  );

  function automatic logic [31:0] preload_word(input logic [9:0] idx);
    case (idx)
      10'h040: preload_word = 32'hDEADBEEF;
      10'h180: preload_word = 32'h600D600D;
      default: preload_word = {6'h2A, idx, 6'h15, idx};
    endcase
  endfunction

  // SRAM model: byte-enabled writes, reads valid RD_LAT cycles after the address
  always @(posedge cclk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= preload_word(10'(i));
    end else begin
      for (int b = 0; b < 4; b++)
        if (m_we[b]) mem[m_adr[11:2]][8*b +: 8] <= m_dw[8*b +: 8];
    end
    rd_pipe[0] <= mem[m_adr[11:2]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign m_dr = rd_pipe[RD_LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic applyStimulus(input logic c_re, input logic [3:0] c_we,
                               input logic [AW-1:0] c_adr, input logic [31:0] c_dw);
    re  = c_re;
    we  = c_we;
    adr = c_adr;
    dw  = c_dw;
  endtask

  // Called just after the negedge of the grant cycle; returns cycles from grant to ack
  task automatic wait_ack(input string tag, output int lat);
    int n;
    n = 0;
    @(negedge cclk);
    while (!p_ack && n < 20) begin
      n++;
      @(negedge cclk);
    end
    if (!p_ack) checkOutput(tag, 32'(p_ack), 32'd1);
    lat = n + 1;
  endtask

  task automatic host_read(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    int lat;
    tick();
    p_re  = 1'b1;
    p_adr = a;
    host_q.push_back('{1'b1, exp});
    tick();
    @(negedge cclk);
    wait_ack(tag, lat);
    tick();
    p_re = 1'b0;
  endtask

  // Scoreboard: core reads are due RD_LAT cycles after acceptance, host results on p_ack
  always @(negedge cclk) begin : monitor
    core_exp_t c;
    host_exp_t h;
    if (!reset && !preload) begin
      if (core_q.size() > 0 && core_q[0].due <= cyc) begin
        c = core_q.pop_front();
        checkOutput("core_dr", dr, c.data);
      end
      if (re && rdy) core_q.push_back('{cyc + RD_LAT, preload_word(adr[11:2])});
      if (p_ack) begin
        if (host_q.size() == 0) begin
          checkOutput("spurious_p_ack", 32'(p_ack), 32'd0);
        end else begin
          h = host_q.pop_front();
          if (h.is_read) checkOutput("host_p_dr", p_dr, h.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    int  cg;
    int  acks;
    int  reads;
    bit  seen;
    logic acc;

    reset = 1'b1;
    applyStimulus(1'b0, 4'h0, '0, '0);
    p_adr = '0;
    p_we  = 1'b0;
    p_re  = 1'b0;
    p_dw  = '0;

    // Test 1: reset held with a core read request present
    tick();
    preload = 1'b0;
    applyStimulus(1'b1, 4'h0, 32'h40, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge cclk);
      checkOutput("rst_m_re", 32'(m_re), 32'd0);
      checkOutput("rst_rdy", 32'(rdy), 32'd1);
      if (i > 0) begin
        checkOutput("rst_p_ack", 32'(p_ack), 32'd0);
        checkOutput("rst_p_dr", p_dr, 32'd0);
        checkOutput("rst_dr", dr, 32'd0);
      end
      if (i < 2) tick();
    end
    tick();
    reset = 1'b0;
    @(negedge cclk);
    checkOutput("t1_m_re_follows", 32'(m_re), 32'd1);
    checkOutput("t1_m_adr", m_adr, 32'h40);
    tick();
    applyStimulus(1'b0, 4'h0, '0, '0);
    repeat (4) tick();

    // Test 2: idle core, host read
    p_re  = 1'b1;
    p_adr = 32'h100;
    host_q.push_back('{1'b1, 32'hDEADBEEF});
    @(negedge cclk);
    checkOutput("t2_no_early_m_re", 32'(m_re), 32'd0);
    tick();
    @(negedge cclk);
    checkOutput("t2_m_re", 32'(m_re), 32'd1);
    checkOutput("t2_m_adr", m_adr, 32'h100);
    checkOutput("t2_m_we", 32'(m_we), 32'd0);
    wait_ack("t2_ack_timeout", lat);
    checkOutput("t2_ack_latency", 32'(lat), 32'(RD_LAT + 1));
    tick();
    p_re = 1'b0;
    @(negedge cclk);
    checkOutput("t2_single_pulse", 32'(p_ack), 32'd0);
    repeat (3) tick();

    // Test 3: core reads every cycle while a host write waits for its slot
    applyStimulus(1'b1, 4'h0, 32'h400, '0);
    p_we  = 1'b1;
    p_adr = 32'h200;
    p_dw  = 32'h12345678;
    host_q.push_back('{1'b0, 32'h0});
    @(negedge cclk);
    checkOutput("t3_first_rdy", 32'(rdy), 32'd1);
    acc  = rdy;
    cg   = 0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (acc) adr = adr + 32'd4;
      @(negedge cclk);
      acc = rdy;
      if (rdy) begin
        cg++;
      end else begin
        seen = 1'b1;
        checkOutput("t3_m_we", 32'(m_we), 32'hF);
        checkOutput("t3_m_adr", m_adr, 32'h200);
        checkOutput("t3_m_dw", m_dw, 32'h12345678);
        checkOutput("t3_m_re", 32'(m_re), 32'd0);
      end
    end
    checkOutput("t3_core_grants", 32'(cg), 32'(STARVE_MAX));
    checkOutput("t3_host_slot", 32'(seen), 32'd1);
    tick();
    @(negedge cclk);
    checkOutput("t3_p_ack", 32'(p_ack), 32'd1);
    checkOutput("t3_rdy_after", 32'(rdy), 32'd1);
    tick();
    applyStimulus(1'b0, 4'h0, '0, '0);
    p_we = 1'b0;
    @(negedge cclk);
    checkOutput("t3_ack_pulse", 32'(p_ack), 32'd0);
    repeat (4) tick();

    // Test 4: core read then host read back to back, results must not swap
    applyStimulus(1'b1, 4'h0, 32'h500, '0);
    p_re  = 1'b1;
    p_adr = 32'h600;
    host_q.push_back('{1'b1, 32'h600D600D});
    @(negedge cclk);
    checkOutput("t4_core_m_adr", m_adr, 32'h500);
    checkOutput("t4_core_m_re", 32'(m_re), 32'd1);
    tick();
    applyStimulus(1'b0, 4'h0, '0, '0);
    @(negedge cclk);
    checkOutput("t4_host_m_adr", m_adr, 32'h600);
    checkOutput("t4_host_m_re", 32'(m_re), 32'd1);
    wait_ack("t4_ack_timeout", lat);
    checkOutput("t4_ack_latency", 32'(lat), 32'(RD_LAT + 1));
    tick();
    p_re = 1'b0;
    @(negedge cclk);
    checkOutput("t4_dr_hold", dr, preload_word(10'h140));
    repeat (3) tick();

    // Test 5: simultaneous host write and read, the write wins
    p_we  = 1'b1;
    p_re  = 1'b1;
    p_adr = 32'h300;
    p_dw  = 32'hCAFEF00D;
    host_q.push_back('{1'b0, 32'h0});
    tick();
    @(negedge cclk);
    checkOutput("t5_m_we", 32'(m_we), 32'hF);
    checkOutput("t5_m_re", 32'(m_re), 32'd0);
    checkOutput("t5_m_adr", m_adr, 32'h300);
    acks  = 0;
    reads = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 1) begin
        p_we = 1'b0;
        p_re = 1'b0;
      end
      @(negedge cclk);
      acks  += int'(p_ack);
      reads += int'(m_re);
    end
    checkOutput("t5_ack_count", 32'(acks), 32'd1);
    checkOutput("t5_no_read", 32'(reads), 32'd0);
    host_read("t5_readback_300", 32'h300, 32'hCAFEF00D);
    host_read("t3_readback_200", 32'h200, 32'h12345678);
    repeat (3) tick();

    // Test 6: reset one cycle after a host read grant drops the access
    p_re  = 1'b1;
    p_adr = 32'h100;
    tick();
    @(negedge cclk);
    checkOutput("t6_grant", 32'(m_re), 32'd1);
    tick();
    reset = 1'b1;
    p_re  = 1'b0;
    @(negedge cclk);
    checkOutput("t6_rst_m_re", 32'(m_re), 32'd0);
    tick();
    reset = 1'b0;
    acks  = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge cclk);
      acks += int'(p_ack);
      tick();
    end
    checkOutput("t6_no_ack", 32'(acks), 32'd0);
    host_read("t6_after_reset", 32'h600, 32'h600D600D);
    repeat (6) tick();

    checkOutput("core_q_drained", 32'(core_q.size()), 32'd0);
    checkOutput("host_q_drained", 32'(host_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
